// File: rtl/full_adder_8bits_pkg.sv
// -----------------------------------------------------------------------------
// full_adder_8bits_pkg
// Shared constants and helpers for the registered ripple-carry adder.
//   AdderWidth      : default operand width of full_adder_8bits
//   signed_overflow : two's-complement overflow from the MSB carry pair
// -----------------------------------------------------------------------------
package full_adder_8bits_pkg;

   localparam int unsigned AdderWidth = 8;

   // Signed overflow occurs when the carry into the MSB differs from the carry out of it.
   function automatic logic signed_overflow(input logic carry_into_msb,
                                            input logic carry_out_msb);
      return carry_into_msb ^ carry_out_msb;
   endfunction

endpackage

// File: rtl/full_adder_1bit.sv
// -----------------------------------------------------------------------------
// full_adder_1bit
// Purely combinational one-bit full-adder cell.
//   a, b  : addend bits
//   c     : carry in
//   sum   : a ^ b ^ c
//   carry : carry out
// -----------------------------------------------------------------------------
module full_adder_1bit (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic carry
);

   logic a_xor_b;

   assign a_xor_b = a ^ b;
   assign sum     = a_xor_b ^ c;
   assign carry   = (a & b) | (c & a_xor_b);

endmodule

// File: rtl/full_adder_8bits.sv
// -----------------------------------------------------------------------------
// full_adder_8bits
// Ripple-carry adder with one clock of latency and registered results.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : A, B, cin valid this cycle
//   A, B      : unsigned WIDTH-bit addends
//   cin       : carry in at bit 0
//   out_valid : S/ovf/zero hold a new result (one cycle after in_valid)
//   S         : WIDTH+1-bit sum, S[WIDTH] is the carry out
//   ovf       : two's-complement overflow of the WIDTH-bit sum
//   zero      : S == 0, decoded from the registered sum
// -----------------------------------------------------------------------------
module full_adder_8bits
   import full_adder_8bits_pkg::*;
#(
   parameter int unsigned WIDTH = AdderWidth
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   output logic             out_valid,
   output logic [WIDTH:0]   S,
   output logic             ovf,
   output logic             zero
);

   // carry[i] is the carry into bit i; carry[WIDTH] is the final carry out.
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_bits;

   assign carry[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_adder_1bit u_fa (
         .a     (A[i]),
         .b     (B[i]),
         .c     (carry[i]),
         .sum   (sum_bits[i]),
         .carry (carry[i+1])
      );
   end

   logic [WIDTH:0] s_d, s_q;
   logic           ovf_d, ovf_q;
   logic           valid_d, valid_q;

   // Results load only on accepted operands; otherwise the last result is held.
   always_comb begin
      s_d     = s_q;
      ovf_d   = ovf_q;
      valid_d = in_valid;
      if (in_valid) begin
         s_d   = {carry[WIDTH], sum_bits};
         ovf_d = signed_overflow(carry[WIDTH-1], carry[WIDTH]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q     <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         s_q     <= s_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
      end
   end

   assign S         = s_q;
   assign ovf       = ovf_q;
   assign out_valid = valid_q;
   assign zero      = (s_q == '0);

endmodule

// File: tb/tb_full_adder_8bits.sv
// -----------------------------------------------------------------------------
// tb_full_adder_8bits
// Directed vectors with hand-computed results; a driver queues expectations
// and an independent monitor pops and compares whenever out_valid is seen.
// -----------------------------------------------------------------------------
module tb_full_adder_8bits;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] A, B;
   logic       cin;
   logic       out_valid;
   logic [8:0] S;
   logic       ovf;
   logic       zero;

   full_adder_8bits #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .cin       (cin),
      .out_valid (out_valid),
      .S         (S),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      int s;
      int ovf;
      int zero;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   hold_s   = 0;
   int   hold_ovf = 0;
   int   hold_z   = 1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Present one operand set for exactly one sampling edge and queue its result.
   task automatic send(input int a, input int b, input int c,
                       input int es, input int eovf, input int ez);
      exp_t e;
      @(negedge clk);
      A = 8'(a); B = 8'(b); cin = c[0]; in_valid = 1'b1;
      e.s = es; e.ovf = eovf; e.zero = ez; e.cyc = cyc + 1;
      sb.push_back(e);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_S"}, int'(S), 0);
      chk({tag, "_ovf"}, int'(ovf), 0);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_zero"}, int'(zero), 1);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      hold_s = 0; hold_ovf = 0; hold_z = 1;
   endtask

   // Monitor: every valid result must match the queue head at the right cycle;
   // idle cycles must show the last result held.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst_n) begin
         if (out_valid) begin
            if (sb.size() == 0) begin
               chk("spurious_out_valid", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("latency_cycle", cyc, e.cyc);
               chk("S", int'(S), e.s);
               chk("ovf", int'(ovf), e.ovf);
               chk("zero", int'(zero), e.zero);
               hold_s = e.s; hold_ovf = e.ovf; hold_z = e.zero;
            end
         end else begin
            if (sb.size() > 0 && sb[0].cyc <= cyc) begin
               e = sb.pop_front();
               chk("missing_out_valid", 0, 1);
            end
            chk("hold_S", int'(S), hold_s);
            chk("hold_ovf", int'(ovf), hold_ovf);
            chk("hold_zero", int'(zero), hold_z);
         end
      end
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; cin = 1'b0;
      #1;
      chk_reset_state("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      send(35, 24, 0, 59, 0, 0);
      send(100, 127, 0, 227, 1, 0);
      send(255, 255, 0, 510, 0, 0);
      send(255, 255, 1, 511, 0, 0);
      idle();
      send(0, 0, 0, 0, 0, 1);
      idle();
      send(255, 0, 1, 256, 0, 0);
      idle();
      @(negedge clk);

      // Four back-to-back operands, then an idle cycle that must hold S.
      send(1, 2, 0, 3, 0, 0);
      send(128, 128, 0, 256, 1, 0);
      send(127, 1, 0, 128, 1, 0);
      send(200, 100, 1, 301, 0, 0);
      idle();
      @(negedge clk);

      // Reset between edges after a result is showing: outputs clear at once.
      send(10, 20, 0, 30, 0, 0);
      @(posedge clk);
      #3;
      apply_reset();
      #1;
      chk_reset_state("async_reset_shown");
      @(negedge clk);
      rst_n = 1'b1;

      // Reset between edges while operands are waiting to be sampled: discarded.
      @(negedge clk);
      A = 8'd77; B = 8'd88; cin = 1'b0; in_valid = 1'b1;
      #2;
      apply_reset();
      #1;
      chk_reset_state("async_reset_pending");
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      send(5, 6, 1, 12, 0, 0);
      idle();

      // Bounded drain of anything still expected.
      repeat (4) @(posedge clk);
      #2;
      chk("scoreboard_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
